// File: rtl/pcie_seq_pkg.sv
// Shared types and default timing constants for the PCIe POR/PERST# sequencer.
package pcie_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_POR_HOLD   = 3'd1,
        ST_PERST_HOLD = 3'd2,
        ST_WAIT_LINK  = 3'd3,
        ST_STABLE     = 3'd4,
        ST_RETRY      = 3'd5,
        ST_DONE       = 3'd6,
        ST_FAIL       = 3'd7
    } seq_state_e;

    localparam int DEF_POR_HOLD_CYCLES    = 500;
    localparam int DEF_PERST_DELAY_CYCLES = 100;
    localparam int DEF_LINKUP_TIMEOUT     = 60000;
    localparam int DEF_STABLE_CYCLES      = 256;
    localparam int DEF_MAX_RETRIES        = 3;
    localparam int DEF_CNT_W              = 16;

    localparam int RETRY_W = 2;

    // A state that must last N cycles loads N-1, because the cycle in which
    // the counter reads zero is itself the last cycle spent in that state.
    function automatic int cnt_load(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/sync2_ff.sv
// Two-flop synchronizer for asynchronous status bits entering the sys_clk domain.
module sync2_ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_perst_sequencer.sv
// Board-level POR / PERST# sequencer: releases POR, then the RP reset and EP
// PERST#, watches link-up, retries training and reports done/fail.
module pcie_perst_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int POR_HOLD_CYCLES    = DEF_POR_HOLD_CYCLES,
    parameter int PERST_DELAY_CYCLES = DEF_PERST_DELAY_CYCLES,
    parameter int LINKUP_TIMEOUT     = DEF_LINKUP_TIMEOUT,
    parameter int STABLE_CYCLES      = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES        = DEF_MAX_RETRIES,
    parameter int CNT_W              = DEF_CNT_W
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               start,
    input  logic               user_lnk_up,
    output logic               por_n_o,
    output logic               rp_rst_n_o,
    output logic [1:0]         ep_perst_n_o,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               lnk_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    localparam logic [CNT_W-1:0]   POR_LOAD    = CNT_W'(cnt_load(POR_HOLD_CYCLES));
    localparam logic [CNT_W-1:0]   PERST_LOAD  = CNT_W'(cnt_load(PERST_DELAY_CYCLES));
    localparam logic [CNT_W-1:0]   LINK_LOAD   = CNT_W'(cnt_load(LINKUP_TIMEOUT));
    localparam logic [CNT_W-1:0]   STABLE_LOAD = CNT_W'(cnt_load(STABLE_CYCLES));
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    seq_state_e         state;
    seq_state_e         state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lnk_lost_nxt;
    logic               lnk;
    logic               por_dec;
    logic               link_rst_dec;
    logic               busy_dec;

    sync2_ff #(
        .WIDTH (1)
    ) u_lnk_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (user_lnk_up),
        .q     (lnk)
    );

    // Next-state, counter reload and output decode for the sequencer FSM.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = (cnt == '0) ? '0 : cnt - 1'b1;
        retry_nxt    = retry_cnt;
        lnk_lost_nxt = lnk_lost;
        por_dec      = 1'b0;
        link_rst_dec = 1'b0;
        busy_dec     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_POR_HOLD;
                    cnt_nxt   = POR_LOAD;
                    retry_nxt = '0;
                end
            end
            ST_POR_HOLD: begin
                busy_dec = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_PERST_HOLD;
                    cnt_nxt   = PERST_LOAD;
                end
            end
            ST_PERST_HOLD: begin
                busy_dec = 1'b1;
                por_dec  = 1'b1;
                if (cnt == '0) begin
                    state_nxt = ST_WAIT_LINK;
                    cnt_nxt   = LINK_LOAD;
                end
            end
            ST_WAIT_LINK: begin
                busy_dec     = 1'b1;
                por_dec      = 1'b1;
                link_rst_dec = 1'b1;
                if (lnk) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = STABLE_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = ST_RETRY;
                    cnt_nxt   = '0;
                end
            end
            ST_STABLE: begin
                busy_dec     = 1'b1;
                por_dec      = 1'b1;
                link_rst_dec = 1'b1;
                if (!lnk) begin
                    state_nxt = ST_RETRY;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_DONE;
                    cnt_nxt   = '0;
                end
            end
            ST_RETRY: begin
                busy_dec     = 1'b1;
                por_dec      = 1'b1;
                link_rst_dec = 1'b1;
                if (retry_cnt == RETRY_MAX) begin
                    state_nxt = ST_FAIL;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_PERST_HOLD;
                    cnt_nxt   = PERST_LOAD;
                    retry_nxt = retry_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                por_dec      = 1'b1;
                link_rst_dec = 1'b1;
                if (start) begin
                    state_nxt    = ST_POR_HOLD;
                    cnt_nxt      = POR_LOAD;
                    retry_nxt    = '0;
                    lnk_lost_nxt = 1'b0;
                end else if (!lnk) begin
                    lnk_lost_nxt = 1'b1;
                end
            end
            ST_FAIL: begin
                if (start) begin
                    state_nxt    = ST_POR_HOLD;
                    cnt_nxt      = POR_LOAD;
                    retry_nxt    = '0;
                    lnk_lost_nxt = 1'b0;
                end
            end
        endcase
    end

    // State, shared counter and registered outputs; outputs follow the state by one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            por_n_o      <= 1'b0;
            rp_rst_n_o   <= 1'b0;
            ep_perst_n_o <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            fail         <= 1'b0;
            lnk_lost     <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            por_n_o      <= por_dec;
            rp_rst_n_o   <= link_rst_dec;
            ep_perst_n_o <= {2{link_rst_dec}};
            busy         <= busy_dec;
            done         <= (state == ST_DONE);
            fail         <= (state == ST_FAIL);
            lnk_lost     <= lnk_lost_nxt;
            retry_cnt    <= retry_nxt;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Self-checking bench for pcie_perst_sequencer: a nominal table plus
// hand-written retry, busy-start, reset and timeout sequences.
module tb_pcie_perst_sequencer;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic       user_lnk_up;
    logic       por_n_o;
    logic       rp_rst_n_o;
    logic [1:0] ep_perst_n_o;
    logic       busy;
    logic       done;
    logic       fail;
    logic       lnk_lost;
    logic [1:0] retry_cnt;
    logic [2:0] state_o;

    logic       start_b;
    logic       lnk_b;
    logic       por_n_b;
    logic       rp_rst_n_b;
    logic [1:0] ep_perst_n_b;
    logic       busy_b;
    logic       done_b;
    logic       fail_b;
    logic       lnk_lost_b;
    logic [1:0] retry_cnt_b;
    logic [2:0] state_b;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    int base     = 0;

    typedef struct {
        int          cyc;
        logic        start;
        logic        lnk;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs [19];

    // Default-timing instance used for the nominal, retry, busy-start and reset tests.
    pcie_perst_sequencer dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start),
        .user_lnk_up  (user_lnk_up),
        .por_n_o      (por_n_o),
        .rp_rst_n_o   (rp_rst_n_o),
        .ep_perst_n_o (ep_perst_n_o),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .lnk_lost     (lnk_lost),
        .retry_cnt    (retry_cnt),
        .state_o      (state_o)
    );

    // Short link-up timeout instance used for the retries-exhausted test.
    pcie_perst_sequencer #(
        .LINKUP_TIMEOUT (200),
        .MAX_RETRIES    (3)
    ) dut_to (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .start        (start_b),
        .user_lnk_up  (lnk_b),
        .por_n_o      (por_n_b),
        .rp_rst_n_o   (rp_rst_n_b),
        .ep_perst_n_o (ep_perst_n_b),
        .busy         (busy_b),
        .done         (done_b),
        .fail         (fail_b),
        .lnk_lost     (lnk_lost_b),
        .retry_cnt    (retry_cnt_b),
        .state_o      (state_b)
    );

    // 100 MHz reference clock.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Free-running edge count so the table can address absolute cycles.
    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [12:0] mk(input logic por, input logic rp, input logic [1:0] ep,
                                       input logic bsy, input logic dn, input logic fl,
                                       input logic lost, input logic [1:0] rty, input logic [2:0] st);
        return {por, rp, ep, bsy, dn, fl, lost, rty, st};
    endfunction

    function automatic logic [12:0] obs_a();
        return {por_n_o, rp_rst_n_o, ep_perst_n_o, busy, done, fail, lnk_lost, retry_cnt, state_o};
    endfunction

    function automatic logic [12:0] obs_b();
        return {por_n_b, rp_rst_n_b, ep_perst_n_b, busy_b, done_b, fail_b, lnk_lost_b, retry_cnt_b, state_b};
    endfunction

    function automatic vec_t row(input int c, input logic s, input logic l, input logic [12:0] e);
        vec_t v;
        v.cyc   = c;
        v.start = s;
        v.lnk   = l;
        v.exp   = e;
        return v;
    endfunction

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic goto(input int e);
        while (edge_cnt - base < e) tick();
    endtask

    task automatic applyStimulus(input logic s, input logic l);
        start       = s;
        user_lnk_up = l;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Hard stop in case something upstream hangs despite the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int low;
        int lat;
        int pulses;
        int idle_bad;
        logic [1:0] ep_prev;

        sys_rst_n   = 1'b0;
        start       = 1'b0;
        user_lnk_up = 1'b0;
        start_b     = 1'b0;
        lnk_b       = 1'b0;

        // Nominal bring-up, link loss in DONE, then restart from DONE; cycles relative to base.
        vecs[0]  = row(9,    1'b1, 1'b0, mk(0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 3'd0));
        vecs[1]  = row(10,   1'b0, 1'b0, mk(0, 0, 2'b00, 0, 0, 0, 0, 2'd0, 3'd1));
        vecs[2]  = row(11,   1'b0, 1'b0, mk(0, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd1));
        vecs[3]  = row(510,  1'b0, 1'b0, mk(0, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd2));
        vecs[4]  = row(511,  1'b0, 1'b0, mk(1, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd2));
        vecs[5]  = row(610,  1'b0, 1'b0, mk(1, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd3));
        vecs[6]  = row(611,  1'b0, 1'b0, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));
        vecs[7]  = row(1611, 1'b0, 1'b1, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));
        vecs[8]  = row(1613, 1'b0, 1'b1, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));
        vecs[9]  = row(1614, 1'b0, 1'b1, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd4));
        vecs[10] = row(1869, 1'b0, 1'b1, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd4));
        vecs[11] = row(1870, 1'b0, 1'b1, mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd6));
        vecs[12] = row(1871, 1'b0, 1'b1, mk(1, 1, 2'b11, 0, 1, 0, 0, 2'd0, 3'd6));
        vecs[13] = row(1900, 1'b0, 1'b0, mk(1, 1, 2'b11, 0, 1, 0, 0, 2'd0, 3'd6));
        vecs[14] = row(1902, 1'b0, 1'b0, mk(1, 1, 2'b11, 0, 1, 0, 0, 2'd0, 3'd6));
        vecs[15] = row(1903, 1'b0, 1'b0, mk(1, 1, 2'b11, 0, 1, 0, 1, 2'd0, 3'd6));
        vecs[16] = row(1910, 1'b1, 1'b0, mk(1, 1, 2'b11, 0, 1, 0, 1, 2'd0, 3'd6));
        vecs[17] = row(1911, 1'b0, 1'b0, mk(1, 1, 2'b11, 0, 1, 0, 0, 2'd0, 3'd1));
        vecs[18] = row(1912, 1'b0, 1'b0, mk(0, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd1));

        tick(3);
        checkOutput("reset_state", obs_a(), 0);
        checkOutput("reset_state_b", obs_b(), 0);
        sys_rst_n = 1'b1;
        tick(2);
        base = edge_cnt;

        for (int i = 0; i < 19; i++) begin
            goto(vecs[i].cyc);
            checkOutput($sformatf("vec%0d", i), obs_a(), vecs[i].exp);
            applyStimulus(vecs[i].start, vecs[i].lnk);
        end

        // A start pulse during WAIT_LINK must be ignored.
        n = 0;
        while (state_o != 3'd3 && n < 1000) begin tick(); n++; end
        checkOutput("reach_wait_link", state_o, 3);
        tick(20);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        checkOutput("busy_start_1", obs_a(), mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));
        tick();
        checkOutput("busy_start_2", obs_a(), mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));

        // Link drops 100 cycles into STABLE; PERST is re-asserted for one PERST_HOLD.
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (state_o != 3'd4 && n < 10) begin tick(); n++; end
        checkOutput("reach_stable", state_o, 4);
        tick(100);
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (ep_perst_n_o != 2'b00 && n < 20) begin tick(); n++; end
        low = 0;
        while (ep_perst_n_o == 2'b00 && low < 300) begin low++; tick(); end
        checkOutput("perst_reassert_len", low, 100);
        checkOutput("retry_after_drop", retry_cnt, 1);
        applyStimulus(1'b0, 1'b1);
        n = 0;
        while (!done && n < 600) begin tick(); n++; end
        checkOutput("done_after_retry", {done, retry_cnt, state_o}, {1'b1, 2'd1, 3'd6});

        // Asynchronous reset in the middle of WAIT_LINK, then no activity without start.
        applyStimulus(1'b0, 1'b0);
        tick(5);
        applyStimulus(1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0);
        n = 0;
        while (state_o != 3'd3 && n < 1000) begin tick(); n++; end
        tick(10);
        checkOutput("pre_reset_wait_link", obs_a(), mk(1, 1, 2'b11, 1, 0, 0, 0, 2'd0, 3'd3));
        sys_rst_n = 1'b0;
        #1;
        checkOutput("async_reset", obs_a(), 0);
        tick(3);
        sys_rst_n = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (obs_a() != 13'd0) idle_bad++;
        end
        checkOutput("idle_after_reset", idle_bad, 0);

        // Link never comes up: four PERST releases, then FAIL with everything asserted.
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        lat     = 0;
        pulses  = 0;
        ep_prev = ep_perst_n_b;
        while (!fail_b && lat < 2500) begin
            tick();
            lat++;
            if (ep_prev == 2'b00 && ep_perst_n_b == 2'b11) pulses++;
            ep_prev = ep_perst_n_b;
        end
        checkOutput("fail_latency", lat, 1705);
        checkOutput("perst_pulses", pulses, 4);
        checkOutput("fail_state", obs_b(), mk(0, 0, 2'b00, 0, 0, 1, 0, 2'd3, 3'd7));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        checkOutput("restart_from_fail", obs_b(), mk(0, 0, 2'b00, 1, 0, 0, 0, 2'd0, 3'd1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcie_perst_sequencer.md
# pcie_perst_sequencer

Board-level power-on and PERST# sequencer for the CPM5 BMD Gen5x8 endpoint simulation environment. Sits directly upstream of the EP/RP pair: it produces the POR release, root-port `sys_rst_n`, and endpoint PERST0N/PERST1N in the correct order. It then watches the link-up indication, retries training on timeout or link loss, and reports pass/fail to the test program.

## Interface
Parameters:
- `POR_HOLD_CYCLES`, default 500: cycles POR and PERST are held asserted after start.
- `PERST_DELAY_CYCLES`, default 100: cycles between POR release and PERST release.
- `LINKUP_TIMEOUT`, default 60000: maximum cycles in WAIT_LINK before a retry.
- `STABLE_CYCLES`, default 256: cycles link-up must stay high continuously before DONE.
- `MAX_RETRIES`, default 3: retries allowed after the first attempt.
- `CNT_W`, default 16: width of the shared down-counter. Every cycle parameter must be ≤ 2^CNT_W−1.

Ports:
- `sys_clk` in 1: reference clock, 100 MHz in the bench.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle pulse that begins or restarts the sequence.
- `user_lnk_up` in 1: link-up from the RP, asynchronous to `sys_clk`.
- `por_n_o` out 1: PS-VIP POR release (1 = released).
- `rp_rst_n_o` out 1: root-port `sys_rst_n`.
- `ep_perst_n_o` out 2: endpoint PERST1N/PERST0N; both bits are always equal.
- `busy` out 1: a sequence is in progress.
- `done` out 1: link trained and stable (sticky).
- `fail` out 1: retries exhausted (sticky).
- `lnk_lost` out 1: link dropped after DONE (sticky).
- `retry_cnt` out 2: retries consumed in the current sequence.
- `state_o` out 3: current FSM state encoding, for debug.

## Operation
- `user_lnk_up` passes through a 2-flop synchronizer. `lnk` below is the synchronized value.
- One down-counter `cnt` is loaded on every state entry. A state's "expiry" is `cnt==0`.

FSM states and transitions:
- **IDLE (0)**:
  - `start` → POR_HOLD, with `retry_cnt` cleared.
- **POR_HOLD (1)**:
  - `por_n_o`, `rp_rst_n_o`, and `ep_perst_n_o` are all 0.
  - Lasts `POR_HOLD_CYCLES` cycles, then → PERST_HOLD.
- **PERST_HOLD (2)**:
  - `por_n_o` = 1; PERST outputs remain 0.
  - Lasts `PERST_DELAY_CYCLES` cycles, then → WAIT_LINK.
- **WAIT_LINK (3)**:
  - `rp_rst_n_o` = 1 and `ep_perst_n_o` = 2'b11.
  - `lnk` = 1 → STABLE.
  - Expiry → RETRY.
- **STABLE (4)**:
  - `lnk` held 1 for `STABLE_CYCLES` cycles → DONE.
  - `lnk` = 0 at any point → RETRY.
- **RETRY (5)**, one cycle:
  - If `retry_cnt` == `MAX_RETRIES` → FAIL.
  - Otherwise `retry_cnt`++ → PERST_HOLD. POR stays released; the PERST outputs go back to 0.
- **DONE (6)**:
  - `done` = 1.
  - `lnk` falling sets `lnk_lost`; there is no automatic retry.
  - `start` → POR_HOLD and clears `done`, `lnk_lost`, and `retry_cnt`.
- **FAIL (7)**:
  - `fail` = 1; all resets return to asserted (0).
  - `start` → POR_HOLD and clears `fail`.

Input rules:
- `start` is ignored while `busy`. `busy` is 1 in states 1–5.
- `start` and a `lnk` edge in the same cycle: `start` takes priority in DONE/FAIL.

## Timing
Reset values (immediate on `sys_rst_n` low):
- State IDLE; `cnt` = 0.
- `por_n_o`, `rp_rst_n_o`, `ep_perst_n_o` = 0.
- `busy`, `done`, `fail`, `lnk_lost` = 0; `retry_cnt` = 0.

All outputs are registered, with changes one cycle after the triggering edge:
- `start` sampled at edge N gives `busy` = 1 at N+1.
- `por_n_o` rises at N+1+`POR_HOLD_CYCLES`.
- PERST outputs rise at N+1+`POR_HOLD_CYCLES`+`PERST_DELAY_CYCLES`.

Link timing:
- `user_lnk_up` to FSM reaction takes 2 synchronizer cycles plus 1 FSM cycle.
- DONE is reached `STABLE_CYCLES`+3 cycles after `user_lnk_up` rises, if it stays high.

Failure and reset timing:
- Worst-case time to FAIL is `POR_HOLD` + (`MAX_RETRIES`+1)·(`PERST_DELAY_CYCLES`+`LINKUP_TIMEOUT`+1) cycles. The full STABLE-drop path adds at most `STABLE_CYCLES` per attempt.
- Reset asserted mid-sequence: outputs drop to their reset values asynchronously. There is no resume; a new `start` is required.
- The counter saturates at 0 and never wraps.

## Structure
- Package `pcie_seq_pkg` holds:
  - `seq_state_e`, a 3-bit enum with the encodings above;
  - the default cycle constants;
  - `RETRY_W` = 2.
- Sub-module `sync2_ff` is the 2-flop synchronizer, reused for any other asynchronous status bits.
- The FSM, counter, and output registers live in a single always_ff plus a combinational next-state block.

## Test plan
1. **Nominal:** `start` at cycle 10; `user_lnk_up` rises 1000 cycles after PERST release and stays high. Expect:
   - `por_n_o` rising at cycle 511;
   - PERST rising at 611;
   - `done` = 1 and `retry_cnt` = 0.
2. **Timeout:** `user_lnk_up` never rises, with `LINKUP_TIMEOUT`=200 and `MAX_RETRIES`=3. Expect:
   - exactly 4 PERST release pulses;
   - `fail` = 1 and `retry_cnt` = 3;
   - all reset outputs back at 0.
3. **Drop during STABLE:** `lnk` drops 100 cycles into STABLE, then rises again on the retry. Expect:
   - PERST re-asserted for 100 cycles;
   - `retry_cnt` = 1;
   - `done` = 1.
4. **Start while busy:** a second `start` pulse during WAIT_LINK. Expect no change to state or counters. A pulse in DONE restarts from POR_HOLD with `done` cleared.
5. **Reset mid-sequence:** `sys_rst_n` pulsed low for 3 cycles mid-WAIT_LINK. Expect:
   - all outputs at 0 within the same timestep;
   - IDLE after release;
   - no activity until the next `start`.
6. **Link loss after DONE:** `user_lnk_up` falls while in DONE. Expect `lnk_lost` = 1 three cycles later, with `done` still 1.
